// File: rtl/stack_pkg.sv
// Shared definitions for the 8-bit LIFO stack block and its bus-master
// controller (stack_reverser).
//   STACK_DATA_WIDTH : default byte width shared with the stack block
//   STACK_DEPTH      : default stack capacity in entries
//   state_t          : controller FSM state encoding
package stack_pkg;

  localparam int STACK_DATA_WIDTH = 8;
  localparam int STACK_DEPTH      = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_POP,
    ST_WAIT,
    ST_OUT,
    ST_DISCARD,
    ST_FAULT
  } state_t;

endpackage

// File: rtl/stack_reverser.sv
// stack_reverser: accepts a byte frame on a valid/ready input stream, pushes
// every byte into an external LIFO stack and, on end of frame, pops them back
// out to a valid/ready output stream in reversed order.
//
// Ports:
//   clk, reset            : single clock, synchronous active-high reset
//   in_valid/in_data/in_last/in_ready     : input byte stream
//   stk_push/stk_pop/stk_data_in          : strobes and data to the stack
//   stk_data_out/stk_error                : stack top byte and fault flag
//   out_valid/out_data/out_last/out_ready : reversed output byte stream
//   trunc : one-cycle pulse, frame longer than DEPTH, excess bytes dropped
//   error : sticky fault, stack reported an error (cleared only by reset)
//   busy  : controller not idle
module stack_reverser
  import stack_pkg::*;
#(
  parameter int DATA_WIDTH = STACK_DATA_WIDTH,
  parameter int DEPTH      = STACK_DEPTH,
  parameter int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  stk_push,
  output logic                  stk_pop,
  output logic [DATA_WIDTH-1:0] stk_data_in,
  input  logic [DATA_WIDTH-1:0] stk_data_out,
  input  logic                  stk_error,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  trunc,
  output logic                  error,
  output logic                  busy
);

  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(DEPTH - 1);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             discard;
  logic             in_fire;
  logic             out_fire;

  // in_ready is a registered flag that is only ever set in IDLE, FILL and
  // DISCARD, so qualifying the push with the filling states is what keeps
  // DISCARD beats out of the stack.
  assign in_fire     = in_valid & in_ready;
  assign out_fire    = out_valid & out_ready;
  assign stk_push    = in_fire & ((state == ST_IDLE) | (state == ST_FILL));
  assign stk_data_in = stk_push ? in_data : '0;

  // Registered outputs are loaded with the value belonging to the state being
  // entered, so each one is valid for exactly the cycles spent in that state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      count     <= '0;
      discard   <= 1'b0;
      in_ready  <= 1'b0;
      stk_pop   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      trunc     <= 1'b0;
      error     <= 1'b0;
      busy      <= 1'b0;
    end else begin
      trunc <= 1'b0;
      if (stk_error || state == ST_FAULT) begin
        state     <= ST_FAULT;
        error     <= 1'b1;
        in_ready  <= 1'b0;
        stk_pop   <= 1'b0;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        busy      <= 1'b1;
      end else begin
        case (state)
          ST_IDLE, ST_FILL: begin
            in_ready <= 1'b1;
            if (in_fire) begin
              count <= count + 1'b1;
              busy  <= 1'b1;
              if (in_last) begin
                state    <= ST_POP;
                in_ready <= 1'b0;
                stk_pop  <= 1'b1;
              end else if (count == LAST_SLOT) begin
                // Stack is now full: drain it and drop the rest of the frame.
                state    <= ST_POP;
                in_ready <= 1'b0;
                stk_pop  <= 1'b1;
                trunc    <= 1'b1;
                discard  <= 1'b1;
              end else begin
                state <= ST_FILL;
              end
            end
          end

          ST_POP: begin
            stk_pop <= 1'b0;
            count   <= count - 1'b1;
            state   <= ST_WAIT;
          end

          ST_WAIT: begin
            // Stack read data is valid one cycle after the pop strobe.
            out_data  <= stk_data_out;
            out_valid <= 1'b1;
            out_last  <= (count == '0);
            state     <= ST_OUT;
          end

          ST_OUT: begin
            if (out_fire) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              if (count != '0) begin
                state   <= ST_POP;
                stk_pop <= 1'b1;
              end else if (discard) begin
                state    <= ST_DISCARD;
                in_ready <= 1'b1;
              end else begin
                state    <= ST_IDLE;
                in_ready <= 1'b1;
                busy     <= 1'b0;
              end
            end
          end

          ST_DISCARD: begin
            in_ready <= 1'b1;
            if (in_fire && in_last) begin
              discard <= 1'b0;
              state   <= ST_IDLE;
              busy    <= 1'b0;
            end
          end

          default: begin
            state <= ST_FAULT;
            busy  <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule
